// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller side drives start/a/b; the subtractor drives status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell reused LSB first,
// with a ripple-borrow flop, sequenced by an IDLE/SHIFT/DONE FSM.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             overflow_reg;

  logic             x_bit;
  logic             y_bit;
  logic             d_bit;
  logic             bo_bit;
  logic             last_bit;
  logic [WIDTH-1:0] res_final;

  // Single full-subtractor cell acting on the current LSBs.
  assign x_bit     = a_sh_reg[0];
  assign y_bit     = b_sh_reg[0];
  assign d_bit     = x_bit ^ y_bit ^ borrow_reg;
  assign bo_bit    = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_reg);
  assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));
  assign res_final = {d_bit, res_sh_reg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      res_sh_reg     <= '0;
      borrow_reg     <= 1'b0;
      cnt_reg        <= '0;
      a_msb_reg      <= 1'b0;
      b_msb_reg      <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            res_sh_reg <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            a_msb_reg  <= bus.a[WIDTH-1];
            b_msb_reg  <= bus.b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_final;
          borrow_reg <= bo_bit;
          cnt_reg    <= cnt_reg + 1'b1;
          // Results are published only on the final bit so they hold across operations.
          if (last_bit) begin
            diff_reg       <= res_final;
            borrow_out_reg <= bo_bit;
            overflow_reg   <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_reg == SHIFT);
  assign bus.done       = (state_reg == DONE);
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_out_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and stepped-sweep checks of serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(2)) if2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_bo, input logic exp_ov);
    int busy_cnt = 0;
    int cyc = 0;
    @(negedge clk);
    check_val({tag, "_idle_done"}, 32'(if8.done), 32'd0);
    if8.start = 1'b1;
    if8.a = a;
    if8.b = b;
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = ~a;
    if8.b = ~b;
    while (!if8.done && cyc < 20) begin
      if (if8.busy) busy_cnt++;
      cyc++;
      @(negedge clk);
    end
    check_val({tag, "_done"},    32'(if8.done), 32'd1);
    check_val({tag, "_latency"}, 32'(cyc), 32'd8);
    check_val({tag, "_busyc"},   32'(busy_cnt), 32'd8);
    check_val({tag, "_busy_in_done"}, 32'(if8.busy), 32'd0);
    check_val({tag, "_diff"},    32'(if8.diff), 32'(exp_d));
    check_val({tag, "_bo"},      32'(if8.borrow_out), 32'(exp_bo));
    check_val({tag, "_ov"},      32'(if8.overflow), 32'(exp_ov));
    $display("[TB] %s a=%02h b=%02h -> diff=%02h bo=%0d ov=%0d", tag, a, b,
             if8.diff, if8.borrow_out, if8.overflow);
  endtask

  task automatic run_op2(input string tag, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] exp_d, input logic exp_bo, input logic exp_ov);
    int cyc = 0;
    @(negedge clk);
    if2.start = 1'b1;
    if2.a = a;
    if2.b = b;
    @(negedge clk);
    if2.start = 1'b0;
    while (!if2.done && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    check_val({tag, "_done"},    32'(if2.done), 32'd1);
    check_val({tag, "_latency"}, 32'(cyc), 32'd2);
    check_val({tag, "_diff"},    32'(if2.diff), 32'(exp_d));
    check_val({tag, "_bo"},      32'(if2.borrow_out), 32'(exp_bo));
    check_val({tag, "_ov"},      32'(if2.overflow), 32'(exp_ov));
    $display("[TB] %s a=%0b b=%0b -> diff=%02b bo=%0d ov=%0d", tag, a, b,
             if2.diff, if2.borrow_out, if2.overflow);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rd;
    int         done_cnt;

    reset = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0;
    #3;
    check_val("rst_busy", 32'(if8.busy), 32'd0);
    check_val("rst_done", 32'(if8.done), 32'd0);
    check_val("rst_diff", 32'(if8.diff), 32'd0);
    check_val("rst_bo",   32'(if8.borrow_out), 32'd0);
    check_val("rst_ov",   32'(if8.overflow), 32'd0);
    check_val("rst_diff2", 32'(if2.diff), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op8("v_5m3",  8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op8("v_3m5",  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op8("v_80m1", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op8("v_eq",   8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

    // Stepped sweep against a word-level reference, back to back.
    for (int ai = 0; ai < 256; ai += 17) begin
      for (int bi = 0; bi < 256; bi += 15) begin
        ra = 8'(ai);
        rb = 8'(bi);
        rd = ra - rb;
        run_op8("sweep", ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]));
      end
    end

    // start held high with operands changing during SHIFT and DONE.
    @(negedge clk);
    if8.start = 1'b1;
    if8.a = 8'h55;
    if8.b = 8'h2A;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      if (if8.done) done_cnt++;
    end
    check_val("hold_done",  32'(if8.done), 32'd1);
    check_val("hold_diff",  32'(if8.diff), 32'h2B);
    check_val("hold_bo",    32'(if8.borrow_out), 32'd0);
    if8.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done) done_cnt++;
    end
    check_val("hold_done_count", 32'(done_cnt), 32'd1);

    run_op8("v_7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Asynchronous reset in the 4th SHIFT cycle.
    @(negedge clk);
    if8.start = 1'b1;
    if8.a = 8'h33;
    if8.b = 8'h11;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_busy", 32'(if8.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_busy", 32'(if8.busy), 32'd0);
    check_val("arst_done", 32'(if8.done), 32'd0);
    check_val("arst_diff", 32'(if8.diff), 32'd0);
    check_val("arst_bo",   32'(if8.borrow_out), 32'd0);
    check_val("arst_ov",   32'(if8.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done) done_cnt++;
    end
    check_val("arst_no_done", 32'(done_cnt), 32'd0);
    run_op8("post_rst", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    run_op2("w2_0m1", 2'b00, 2'b01, 2'b11, 1'b1, 1'b0);
    run_op2("w2_1m2", 2'b01, 2'b10, 2'b11, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
